// File: rtl/dmem_banked.sv
// dmem_banked: byte-addressable data memory with sized accesses, byte-lane
// writes, a registered read port and a post-reset clearing sweep.
// Optional feature macro: DMEM_MAILBOX_EN (word 0 tracks the status input).
module dmem_banked #(
  parameter int ADDR_W     = 19,
  parameter int DEPTH      = 501,
  parameter int WORD_BYTES = 2,
  parameter int STATUS_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [1:0]              size,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [8*WORD_BYTES-1:0] wd,
  input  logic [STATUS_W-1:0]     status,
  output logic                    ready,
  output logic                    busy,
  output logic                    rvalid,
  output logic [8*WORD_BYTES-1:0] rd,
  output logic                    err
);
  localparam int W     = 8 * WORD_BYTES;
  localparam int LOG2  = $clog2(WORD_BYTES);
  localparam int OFF_W = (LOG2 > 0) ? LOG2 : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic S_INIT = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic             state;
  logic [IDX_W-1:0] cnt;
  logic [W-1:0]     mem [DEPTH];

  logic [ADDR_W-1:0]     idx;
  logic [OFF_W-1:0]      off;
  int unsigned           off_u;
  int unsigned           nbytes;
  logic                  in_range;
  logic                  legal;
  logic                  accept;
  logic                  last_clear;
  logic [IDX_W-1:0]      idx_c;
  logic [WORD_BYTES-1:0] lane_en;
  logic [W-1:0]          wd_sh;
  logic [W-1:0]          rmask;
  logic [W-1:0]          rword;
  logic [W-1:0]          rd_n;

`ifdef DMEM_MAILBOX_EN
  logic [W-1:0] stat_ext;
  assign stat_ext = W'(status);
`else
  logic unused_status;
  assign unused_status = ^status;
`endif

  assign off        = (LOG2 > 0) ? addr[OFF_W-1:0] : '0;
  assign ready      = (state == S_RUN);
  assign busy       = (state == S_INIT);
  assign accept     = req && ready;
  assign last_clear = (state == S_INIT) && (cnt == IDX_W'(DEPTH - 1));

  // Decode the access: legality, byte lanes, aligned write data, read result.
  always_comb begin
    idx      = addr >> LOG2;
    off_u    = 32'(off);
    nbytes   = 32'd1 << size;
    in_range = 32'(idx) < 32'(DEPTH);
    legal    = (nbytes <= 32'(WORD_BYTES)) && ((off_u & (nbytes - 32'd1)) == 32'd0) && in_range;
    idx_c    = in_range ? idx[IDX_W-1:0] : '0;
    lane_en  = '0;
    rmask    = '0;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      lane_en[b]     = (b >= off_u) && (b < off_u + nbytes);
      rmask[8*b +: 8] = (b < nbytes) ? 8'hFF : 8'h00;
    end
    wd_sh = wd << (8 * off_u);
    rword = mem[idx_c];
`ifdef DMEM_MAILBOX_EN
    // Word 0 reads return status as seen at the accepting edge, not the stored copy.
    if (idx_c == '0) rword = stat_ext;
`endif
    rd_n = legal ? ((rword >> (8 * off_u)) & rmask) : '0;
  end

  // Storage: clearing sweep in INIT, byte-lane writes in RUN (no reset on the array).
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
`ifdef DMEM_MAILBOX_EN
      if (last_clear) mem[0] <= stat_ext;
`endif
    end else begin
      if (accept && we && legal) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (lane_en[b]) mem[idx_c][8*b +: 8] <= wd_sh[8*b +: 8];
        end
      end
`ifdef DMEM_MAILBOX_EN
      // Placed last so the mailbox load wins over a same-cycle write to word 0.
      mem[0] <= stat_ext;
`endif
    end
  end

  // Control: sweep counter, state, registered read data and response pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_INIT;
      cnt    <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rd     <= '0;
    end else begin
      rvalid <= accept && !we;
      err    <= accept && !legal;
      if (accept && !we) rd <= rd_n;
      if (state == S_INIT) begin
        if (last_clear) state <= S_RUN;
        else            cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked at WORD_BYTES=2, DEPTH=501.
module tb_dmem_banked;
  localparam int ADDR_W = 19;
  localparam int DEPTH  = 501;

  logic              clk    = 1'b0;
  logic              reset  = 1'b0;
  logic              req    = 1'b0;
  logic              we     = 1'b0;
  logic [1:0]        size   = 2'd0;
  logic [ADDR_W-1:0] addr   = '0;
  logic [15:0]       wd     = '0;
  logic [3:0]        status = 4'h9;
  logic              ready, busy, rvalid, err;
  logic [15:0]       rd;

  int total = 0;
  int bad   = 0;

  dmem_banked #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_BYTES(2), .STATUS_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wd(wd), .status(status), .ready(ready), .busy(busy), .rvalid(rvalid),
    .rd(rd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s,
                       input logic [ADDR_W-1:0] a, input logic [15:0] d);
    req = r; we = w; size = s; addr = a; wd = d;
  endtask

  task automatic test_reset();
    int miss;
    #2;
    total++;
    if (ready !== 1'b0 || busy !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL reset_values ready=%b busy=%b rvalid=%b err=%b rd=%h expected 0 1 0 0 0000",
               ready, busy, rvalid, err, rd);
    end
    tick(); tick();
    reset = 1'b1;
    miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready !== 1'b0 || busy !== 1'b1) miss++;
      tick();
    end
    total++;
    if (miss != 0) begin
      bad++;
      $display("FAIL sweep_len early_ready_cycles=%0d expected 0", miss);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL run_entry ready=%b busy=%b expected 1 0", ready, busy);
    end
    drive(1, 0, 2'd1, 19'h00002, 16'h0);
    tick();
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h0000 || err !== 1'b0) begin
      bad++;
      $display("FAIL first_read rvalid=%b rd=%h err=%b expected 1 0000 0", rvalid, rd, err);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 2'd1, 19'h00010, 16'hBEEF);
    tick();
    total++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL write_no_rvalid rvalid=%b err=%b expected 0 0", rvalid, err);
    end
    drive(1, 0, 2'd0, 19'h00010, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h00EF) begin
      bad++;
      $display("FAIL byte_lo rvalid=%b rd=%h expected 1 00ef", rvalid, rd);
    end
    drive(1, 0, 2'd0, 19'h00011, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h00BE) begin
      bad++;
      $display("FAIL byte_hi rvalid=%b rd=%h expected 1 00be", rvalid, rd);
    end
    drive(1, 0, 2'd1, 19'h00010, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b1 || rd !== 16'hBEEF) begin
      bad++;
      $display("FAIL half_read rvalid=%b rd=%h expected 1 beef", rvalid, rd);
    end
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b0 || rd !== 16'hBEEF) begin
      bad++;
      $display("FAIL rd_hold rvalid=%b rd=%h expected 0 beef", rvalid, rd);
    end
  endtask

  task automatic test_lanes();
    drive(1, 1, 2'd1, 19'h00020, 16'h1234);
    tick();
    drive(1, 1, 2'd0, 19'h00021, 16'h005A);
    tick();
    drive(1, 0, 2'd1, 19'h00020, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h5A34) begin
      bad++;
      $display("FAIL lane_hi rvalid=%b rd=%h expected 1 5a34", rvalid, rd);
    end
    drive(1, 1, 2'd0, 19'h00020, 16'hAA77);
    tick();
    drive(1, 0, 2'd1, 19'h00020, 16'h0);
    tick();
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h5A77) begin
      bad++;
      $display("FAIL lane_lo rvalid=%b rd=%h expected 1 5a77", rvalid, rd);
    end
  endtask

  task automatic test_illegal();
    drive(1, 1, 2'd1, 19'h00031, 16'hABCD);
    tick();
    total++;
    if (err !== 1'b1 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_wr err=%b rvalid=%b expected 1 0", err, rvalid);
    end
    drive(1, 0, 2'd1, 19'h00030, 16'h0);
    tick();
    total++;
    if (err !== 1'b0 || rvalid !== 1'b1 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL misalign_nochange err=%b rvalid=%b rd=%h expected 0 1 0000", err, rvalid, rd);
    end
    drive(1, 0, 2'd1, 19'h00010, 16'h0);
    tick();
    drive(1, 0, 2'd2, 19'h00004, 16'h0);
    tick();
    total++;
    if (err !== 1'b1 || rvalid !== 1'b1 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL oversize_rd err=%b rvalid=%b rd=%h expected 1 1 0000", err, rvalid, rd);
    end
    drive(1, 0, 2'd1, 19'h003E8, 16'h0);
    tick();
    total++;
    if (err !== 1'b0 || rvalid !== 1'b1) begin
      bad++;
      $display("FAIL last_word err=%b rvalid=%b expected 0 1", err, rvalid);
    end
    drive(1, 0, 2'd1, 19'h003EA, 16'h0);
    tick();
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    total++;
    if (err !== 1'b1 || rvalid !== 1'b1 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL range_rd err=%b rvalid=%b rd=%h expected 1 1 0000", err, rvalid, rd);
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse err=%b expected 0", err);
    end
  endtask

  task automatic test_mailbox();
    logic [15:0] exp_mb;
`ifdef DMEM_MAILBOX_EN
    exp_mb = 16'h0009;
`else
    exp_mb = 16'hFFFF;
`endif
    drive(1, 1, 2'd1, 19'h00000, 16'hFFFF);
    tick();
    drive(1, 0, 2'd1, 19'h00000, 16'h0);
    tick();
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    total++;
    if (rvalid !== 1'b1 || rd !== exp_mb) begin
      bad++;
      $display("FAIL mailbox rvalid=%b rd=%h expected 1 %h", rvalid, rd, exp_mb);
    end
  endtask

  task automatic test_reset_mid();
    int miss;
    // Reset during INIT cycle 100
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (100) tick();
    #2 reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || busy !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL init_reset ready=%b busy=%b rvalid=%b err=%b rd=%h expected 0 1 0 0 0000",
               ready, busy, rvalid, err, rd);
    end
    tick(); tick();
    reset = 1'b1;
    miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready !== 1'b0) miss++;
      tick();
    end
    total++;
    if (miss != 0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL resweep1 early_ready_cycles=%0d ready=%b expected 0 1", miss, ready);
    end
    // Reset with a read in flight
    drive(1, 1, 2'd1, 19'h00010, 16'hBEEF);
    tick();
    drive(1, 0, 2'd1, 19'h00010, 16'h0);
    tick();
    total++;
    if (rvalid !== 1'b1 || rd !== 16'hBEEF) begin
      bad++;
      $display("FAIL pre_reset_rd rvalid=%b rd=%h expected 1 beef", rvalid, rd);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || busy !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL run_reset ready=%b busy=%b rvalid=%b err=%b rd=%h expected 0 1 0 0 0000",
               ready, busy, rvalid, err, rd);
    end
    tick();
    total++;
    if (rvalid !== 1'b0 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold rvalid=%b rd=%h expected 0 0000", rvalid, rd);
    end
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    reset = 1'b1;
    miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready !== 1'b0) miss++;
      tick();
    end
    total++;
    if (miss != 0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL resweep2 early_ready_cycles=%0d ready=%b expected 0 1", miss, ready);
    end
    drive(1, 0, 2'd1, 19'h00010, 16'h0);
    tick();
    drive(0, 0, 2'd0, 19'h0, 16'h0);
    total++;
    if (rvalid !== 1'b1 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL cleared_rd rvalid=%b rd=%h expected 1 0000", rvalid, rd);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lanes();
    test_illegal();
    test_mailbox();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
